// File: rtl/sr_regfile_sb_pkg.sv
// Package shared by the register file and its scoreboard.
// Contents: the hazard-cause record that the scoreboard raises, and an
// address-liveness helper. Address 0 is hard-wired, so an operation that
// targets it does nothing.
package sr_regfile_sb_pkg;

  // Widest address the liveness helper accepts. Callers zero-extend to this width.
  localparam int SR_AW_MAX = 16;

  // Individual causes of a hazard violation, all evaluated in the same cycle.
  typedef struct packed {
    logic collide;    // primary write and completion hit the same register
    logic reissue;    // issue to a register that is already pending
    logic orphan_cw;  // completion to a register that is not pending
    logic wr_busy;    // primary write to a pending register
  } sb_haz_t;

  // An operation is live only when it is valid and does not target register 0.
  function automatic logic addr_live(input logic valid, input logic [SR_AW_MAX-1:0] addr);
    return valid && (addr != {SR_AW_MAX{1'b0}});
  endfunction

  // Any cause present makes the cycle a violation.
  function automatic logic haz_any(input sb_haz_t h);
    return |h;
  endfunction

endpackage

// File: rtl/sr_cpu.vh
// Shared CPU configuration header.
// Holds the default register-file geometry used by sr_regfile_sb.
//
// SR_RF_BYPASS_EN: define this macro to forward same-cycle completion and
// primary writes to the register-file read ports. When it is not defined,
// reads return only stored state, and a write becomes visible on the next cycle.
`ifndef SR_CPU_VH
`define SR_CPU_VH

`define SR_CPU_XLEN 32
`define SR_CPU_NREG 32
`define SR_CPU_NRD  3

`endif

// File: rtl/sr_rf_scoreboard.sv
// Pending-write scoreboard for sr_regfile_sb.
// Tracks one busy bit per register, the registered count of busy bits,
// and a sticky hazard-violation flag.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   i_we, i_wa                       primary write (used only for hazard detection)
//   i_iss_valid, i_iss_addr          multi-cycle issue: the destination becomes busy
//   i_cw_valid, i_cw_addr            multi-cycle completion: the destination is released
//   o_busy [NREG]                    busy bit per register
//   o_pend_cnt [AW+1]                number of busy registers
//   o_err                            sticky hazard flag
module sr_rf_scoreboard
  import sr_regfile_sb_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic            i_iss_valid,
  input  logic [AW-1:0]   i_iss_addr,
  input  logic            i_cw_valid,
  input  logic [AW-1:0]   i_cw_addr,
  output logic [NREG-1:0] o_busy,
  output logic [AW:0]     o_pend_cnt,
  output logic            o_err
);

  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_pend_cnt;
  logic            r_err;

  logic            w_we_v;
  logic            w_iss_v;
  logic            w_cw_v;
  logic            w_hit_cw_iss;
  logic            w_hit_cw_we;
  logic [NREG-1:0] w_busy_nxt;
  logic [AW:0]     w_cnt_nxt;
  sb_haz_t         w_haz;

  assign w_we_v  = addr_live(i_we,        SR_AW_MAX'(i_wa));
  assign w_iss_v = addr_live(i_iss_valid, SR_AW_MAX'(i_iss_addr));
  assign w_cw_v  = addr_live(i_cw_valid,  SR_AW_MAX'(i_cw_addr));

  assign w_hit_cw_iss = w_cw_v && w_iss_v && (i_cw_addr == i_iss_addr);
  assign w_hit_cw_we  = w_cw_v && w_we_v  && (i_cw_addr == i_wa);

  // Next busy vector and its population count.
  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = {(AW+1){1'b0}};
    for (int k = 0; k < NREG; k++) begin
      // An issue beats a completion to the same register: the new op keeps it pending.
      w_busy_nxt[k] = (w_iss_v && (i_iss_addr == AW'(k))) ? 1'b1 :
                      (w_cw_v  && (i_cw_addr  == AW'(k))) ? 1'b0 : r_busy[k];
      w_cnt_nxt     = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[k]};
    end
  end

  // Hazard causes for this cycle.
  always_comb begin
    w_haz.collide   = w_hit_cw_we;
    w_haz.reissue   = w_iss_v && r_busy[i_iss_addr] && !w_hit_cw_iss;
    // A completion that meets a same-cycle reissue of its register is a normal hand-over.
    w_haz.orphan_cw = w_cw_v && !r_busy[i_cw_addr] && !w_hit_cw_iss;
    w_haz.wr_busy   = w_we_v && r_busy[i_wa] && !w_hit_cw_we;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy     <= {NREG{1'b0}};
      r_pend_cnt <= {(AW+1){1'b0}};
      r_err      <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_cnt_nxt;
      r_err      <= r_err | haz_any(w_haz);
    end
  end

  assign o_busy     = r_busy;
  assign o_pend_cnt = r_pend_cnt;
  assign o_err      = r_err;

endmodule

// File: rtl/sr_regfile_sb.sv
// Register file with a pending-write scoreboard.
// Register 0 always reads as zero. Reads are combinational.
// Configuration macro: SR_RF_BYPASS_EN. When it is defined, same-cycle
// completion and primary-write data are forwarded to the read ports.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   ra [NRD*AW]                  read addresses; port i at [i*AW +: AW]
//   rdata [NRD*XLEN]             read data; port i at [i*XLEN +: XLEN]
//   rbusy [NRD]                  the addressed register has a pending write
//   we, wa, wd                   primary single-cycle write
//   iss_valid, iss_addr          multi-cycle issue
//   cw_valid, cw_addr, cw_data   multi-cycle completion write
//   pend_cnt [AW+1]              number of pending registers
//   err                          sticky hazard-violation flag
`include "sr_cpu.vh"

module sr_regfile_sb
  import sr_regfile_sb_pkg::*;
#(
  parameter  int XLEN = `SR_CPU_XLEN,
  parameter  int NREG = `SR_CPU_NREG,
  parameter  int NRD  = `SR_CPU_NRD,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  input  logic                cw_valid,
  input  logic [AW-1:0]       cw_addr,
  input  logic [XLEN-1:0]     cw_data,
  output logic [AW:0]         pend_cnt,
  output logic                err
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] w_busy;
  logic [AW-1:0]   w_ra [NRD];
  logic            w_we_v;
  logic            w_cw_v;

  assign w_we_v = addr_live(we,       SR_AW_MAX'(wa));
  assign w_cw_v = addr_live(cw_valid, SR_AW_MAX'(cw_addr));

  for (genvar g = 0; g < NRD; g++) begin : g_ra
    assign w_ra[g] = ra[g*AW +: AW];
  end

  sr_rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (we),
    .i_wa        (wa),
    .i_iss_valid (iss_valid),
    .i_iss_addr  (iss_addr),
    .i_cw_valid  (cw_valid),
    .i_cw_addr   (cw_addr),
    .o_busy      (w_busy),
    .o_pend_cnt  (pend_cnt),
    .o_err       (err)
  );

  // Register storage. A primary write is applied after the completion, so the primary data wins on a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        r_regs[k] <= {XLEN{1'b0}};
      end
    end else begin
      if (w_cw_v) begin
        r_regs[cw_addr] <= cw_data;
      end
      if (w_we_v) begin
        r_regs[wa] <= wd;
      end
    end
  end

  // Combinational read ports, with optional same-cycle forwarding.
  always_comb begin
    rdata = {(NRD*XLEN){1'b0}};
    rbusy = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      if (w_ra[i] == {AW{1'b0}}) begin
        rdata[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rbusy[i]              = 1'b0;
      end
`ifdef SR_RF_BYPASS_EN
      else if (w_cw_v && (cw_addr == w_ra[i])) begin
        rdata[i*XLEN +: XLEN] = cw_data;
        rbusy[i]              = 1'b0;
      end else if (w_we_v && (wa == w_ra[i])) begin
        rdata[i*XLEN +: XLEN] = wd;
        rbusy[i]              = w_busy[w_ra[i]];
      end
`endif
      else begin
        rdata[i*XLEN +: XLEN] = r_regs[w_ra[i]];
        rbusy[i]              = w_busy[w_ra[i]];
      end
    end
  end

endmodule

// File: tb/tb_sr_regfile_sb.sv
// Self-checking bench for sr_regfile_sb. A behavioural model of the register
// file follows the architectural rules, and one compare process checks every
// output against it on each falling edge. Literal checks at the key points of
// each directed sequence pin the model itself.
module tb_sr_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 3;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                cw_valid;
  logic [AW-1:0]       cw_addr;
  logic [XLEN-1:0]     cw_data;
  logic [AW:0]         pend_cnt;
  logic                err;

  int n_chk = 0;
  int n_err = 0;

  // Architectural model state.
  logic [XLEN-1:0] m_reg  [NREG];
  logic            m_busy [NREG];
  logic            m_err;
  bit              m_valid = 1'b0;

  always #5 clk = ~clk;

  sr_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rdata(rdata), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .cw_valid(cw_valid), .cw_addr(cw_addr), .cw_data(cw_data),
    .pend_cnt(pend_cnt), .err(err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Hazard rules, written directly from the architectural description.
  function automatic bit f_hazard();
    bit wv, iv, cv;
    wv = we        && (wa != 5'd0);
    iv = iss_valid && (iss_addr != 5'd0);
    cv = cw_valid  && (cw_addr != 5'd0);
    if (wv && cv && wa == cw_addr) return 1'b1;                                  // collision
    if (iv && m_busy[iss_addr] && !(cv && cw_addr == iss_addr)) return 1'b1;     // reissue
    if (cv && !m_busy[cw_addr] && !(iv && iss_addr == cw_addr)) return 1'b1;     // orphan completion
    if (wv && m_busy[wa] && !(cv && cw_addr == wa)) return 1'b1;                 // write to pending
    return 1'b0;
  endfunction

  // Model update on each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        m_reg[k]  <= 32'd0;
        m_busy[k] <= 1'b0;
      end
      m_err   <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      m_err <= m_err | f_hazard();
      if (cw_valid && cw_addr != 5'd0) begin
        m_reg[cw_addr]  <= cw_data;
        m_busy[cw_addr] <= 1'b0;
      end
      if (iss_valid && iss_addr != 5'd0) m_busy[iss_addr] <= 1'b1;
      if (we && wa != 5'd0) m_reg[wa] <= wd;
    end
  end

  function automatic logic [XLEN-1:0] exp_rdata(input int i);
    logic [AW-1:0] a;
    a = ra[i*AW +: AW];
    if (a == 5'd0) return 32'd0;
`ifdef SR_RF_BYPASS_EN
    if (cw_valid && cw_addr == a) return cw_data;
    if (we && wa == a) return wd;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_rbusy(input int i);
    logic [AW-1:0] a;
    a = ra[i*AW +: AW];
    if (a == 5'd0) return 1'b0;
`ifdef SR_RF_BYPASS_EN
    if (cw_valid && cw_addr == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic int model_pend();
    int c = 0;
    for (int k = 0; k < NREG; k++) c += int'(m_busy[k]);
    return c;
  endfunction

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < NRD; i++) begin
        check($sformatf("cmp_rdata%0d", i), rdata[i*XLEN +: XLEN], exp_rdata(i));
        check($sformatf("cmp_rbusy%0d", i), 32'(rbusy[i]), 32'(exp_rbusy(i)));
      end
      check("cmp_pend_cnt", 32'(pend_cnt), 32'(model_pend()));
      check("cmp_err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = 5'd0; wd = 32'd0;
    iss_valid = 1'b0; iss_addr = 5'd0;
    cw_valid = 1'b0; cw_addr = 5'd0; cw_data = 32'd0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ra = {a2, a1, a0};
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic lit(input string name, input int port, input logic [31:0] exp_d, input logic exp_b);
    #2;
    check({name, "_rdata"}, rdata[port*XLEN +: XLEN], exp_d);
    check({name, "_rbusy"}, 32'(rbusy[port]), 32'(exp_b));
  endtask

  task automatic lit_sb(input string name, input int exp_p, input logic exp_e);
    check({name, "_pend"}, 32'(pend_cnt), 32'(exp_p));
    check({name, "_err"}, 32'(err), 32'(exp_e));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_ra(5'd0, 5'd5, 5'd7);
    tick();
    tick();
    rst_n = 1'b1;
    lit("reset", 1, 32'd0, 1'b0);
    lit_sb("reset", 0, 1'b0);

    // Primary write, then read back. Register 0 stays zero.
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    tick();
    idle();
    set_ra(5'd0, 5'd5, 5'd7);
    lit("wr5", 1, 32'hDEADBEEF, 1'b0);
    lit("r0", 0, 32'd0, 1'b0);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    cw_valid = 1'b1; cw_addr = 5'd0; cw_data = 32'h1;
    tick();
    idle();
    lit("r0_wr", 0, 32'd0, 1'b0);
    lit_sb("r0_wr", 0, 1'b0);

    // Issue and completion of register 7.
    iss_valid = 1'b1; iss_addr = 5'd7;
    tick();
    idle();
    lit("iss7", 2, 32'd0, 1'b1);
    lit_sb("iss7", 1, 1'b0);
    cw_valid = 1'b1; cw_addr = 5'd7; cw_data = 32'h12345678;
    tick();
    idle();
    lit("cw7", 2, 32'h12345678, 1'b0);
    lit_sb("cw7", 0, 1'b0);

    // A primary write and a completion to different registers in the same cycle.
    iss_valid = 1'b1; iss_addr = 5'd10;
    tick();
    idle();
    we = 1'b1; wa = 5'd11; wd = 32'h0000AAAA;
    cw_valid = 1'b1; cw_addr = 5'd10; cw_data = 32'h0000BBBB;
    tick();
    idle();
    set_ra(5'd10, 5'd11, 5'd7);
    lit("dual10", 0, 32'h0000BBBB, 1'b0);
    lit("dual11", 1, 32'h0000AAAA, 1'b0);
    lit_sb("dual", 0, 1'b0);

    // Issue and completion to the same register in one cycle: the register stays busy, with no error.
    iss_valid = 1'b1; iss_addr = 5'd12;
    tick();
    iss_valid = 1'b1; iss_addr = 5'd12;
    cw_valid = 1'b1; cw_addr = 5'd12; cw_data = 32'h5555;
    tick();
    idle();
    set_ra(5'd12, 5'd0, 5'd0);
    lit("handover", 0, 32'h5555, 1'b1);
    lit_sb("handover", 1, 1'b0);
    cw_valid = 1'b1; cw_addr = 5'd12; cw_data = 32'h6666;
    tick();
    idle();
    lit_sb("handover_done", 0, 1'b0);

    // Issue register 3 twice. The error is sticky until reset.
    iss_valid = 1'b1; iss_addr = 5'd3;
    tick();
    tick();
    idle();
    lit_sb("reissue", 1, 1'b1);
    tick();
    tick();
    lit_sb("sticky", 1, 1'b1);
    do_reset();
    lit_sb("sticky_clr", 0, 1'b0);

    // A primary write collides with a completion: the primary data wins.
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    we = 1'b1; wa = 5'd9; wd = 32'h1;
    cw_valid = 1'b1; cw_addr = 5'd9; cw_data = 32'h2;
    tick();
    idle();
    set_ra(5'd9, 5'd0, 5'd0);
    lit("collide", 0, 32'h1, 1'b0);
    lit_sb("collide", 0, 1'b1);
    do_reset();

    // A primary write to a busy register.
    iss_valid = 1'b1; iss_addr = 5'd6;
    tick();
    idle();
    we = 1'b1; wa = 5'd6; wd = 32'd77;
    tick();
    idle();
    set_ra(5'd6, 5'd0, 5'd0);
    lit("wr_busy", 0, 32'd77, 1'b1);
    lit_sb("wr_busy", 1, 1'b1);
    do_reset();

    // A completion to a register that is not busy.
    cw_valid = 1'b1; cw_addr = 5'd8; cw_data = 32'd99;
    tick();
    idle();
    set_ra(5'd8, 5'd0, 5'd0);
    lit("orphan", 0, 32'd99, 1'b0);
    lit_sb("orphan", 0, 1'b1);
    do_reset();

    // Issue four registers, then reset while other inputs are active.
    for (int k = 1; k <= 4; k++) begin
      iss_valid = 1'b1; iss_addr = AW'(k);
      tick();
    end
    idle();
    #2;
    lit_sb("four", 4, 1'b0);
    we = 1'b1; wa = 5'd5; wd = 32'h77;
    iss_valid = 1'b1; iss_addr = 5'd6;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    set_ra(5'd1, 5'd2, 5'd5);
    lit("rst_r1", 0, 32'd0, 1'b0);
    lit("rst_r5", 2, 32'd0, 1'b0);
    lit_sb("rst_four", 0, 1'b0);
    cw_valid = 1'b1; cw_addr = 5'd2; cw_data = 32'd42;
    tick();
    idle();
    lit("late_cw", 1, 32'd42, 1'b0);
    lit_sb("late_cw", 0, 1'b1);
    do_reset();

    // Read of a register whose completion arrives in the same cycle.
    we = 1'b1; wa = 5'd4; wd = 32'h1111;
    tick();
    idle();
    iss_valid = 1'b1; iss_addr = 5'd4;
    tick();
    idle();
    set_ra(5'd0, 5'd0, 5'd4);
    cw_valid = 1'b1; cw_addr = 5'd4; cw_data = 32'hCAFE0000;
`ifdef SR_RF_BYPASS_EN
    lit("fwd", 2, 32'hCAFE0000, 1'b0);
`else
    lit("fwd", 2, 32'h1111, 1'b1);
`endif
    tick();
    idle();
    lit("fwd_after", 2, 32'hCAFE0000, 1'b0);
    lit_sb("fwd_after", 0, 1'b0);

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sr_regfile_sb.md
SR_REGFILE_SB -- requirements
Module: sr_regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, ≥2); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 3, read port count (port 0 = debug).
REQ-004 SHALL have clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ra  in  NRD*AW  read addresses, port i at bits [i*AW +: AW].
REQ-007 SHALL have rdata  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN].
REQ-008 SHALL have rbusy  out  NRD  port i address has pending write.
REQ-009 SHALL have we, wa, wd  in  1/AW/XLEN  primary single-cycle write port.
REQ-010 SHALL have iss_valid, iss_addr  in  1/AW  multi-cycle op issue: mark destination pending.
REQ-011 SHALL have cw_valid, cw_addr, cw_data  in  1/AW/XLEN  multi-cycle completion write.
REQ-012 SHALL have pend_cnt  out  AW+1  number of pending registers.
REQ-013 SHALL have err  out  1  sticky hazard-violation flag.

Function
REQ-014 Register 0 SHALL read as zero; writes, issues and completions to address 0 SHALL be ignored.
REQ-015 Reads SHALL be combinational: rdata[i] = reg[ra[i]], rbusy[i] = busy[ra[i]].
REQ-016 we=1, wa≠0 SHALL write wd to reg[wa] at next edge.
REQ-017 cw_valid=1, cw_addr≠0 SHALL write cw_data to reg[cw_addr] and clear busy[cw_addr] at next edge.
REQ-018 we and cw_valid to different addresses in one cycle SHALL both take effect.
REQ-019 we and cw_valid to the same nonzero address SHALL write wd (primary wins), clear busy, set err.
REQ-020 iss_valid, iss_addr≠0 SHALL set busy[iss_addr] at next edge.
REQ-021 iss_valid to an already-busy address (not being completed that cycle) SHALL set err; busy stays 1.
REQ-022 iss_valid and cw_valid to the same address in one cycle SHALL write cw_data and leave busy=1, no err.
REQ-023 cw_valid to a non-busy address SHALL still write data and SHALL set err.
REQ-024 we to a busy address (no same-cycle completion) SHALL write and SHALL set err; busy unchanged.
REQ-025 pend_cnt SHALL equal popcount(busy) registered, updated in the same edge as busy.
REQ-026 err SHALL remain 1 until reset.

Reset
REQ-027 On rising clk with rst_n=0: all registers, busy bits, pend_cnt, err SHALL become 0; rdata and rbusy therefore 0 from the next cycle.
REQ-028 Reset SHALL override all write/issue/completion inputs in the same cycle; an in-flight multi-cycle op's later completion SHALL set err per REQ-023.

Configuration
REQ-029 Macro SR_RF_BYPASS_EN defined: read port with ra[i]≠0 matching an active cw_valid address SHALL return cw_data and rbusy[i]=0 same cycle; else matching active we returns wd; cw has priority over we.
REQ-030 Macro SR_RF_BYPASS_EN undefined: reads SHALL return only stored state (write visible next cycle).

Structure
REQ-031 Shared header sr_cpu.vh SHALL hold default XLEN/NREG/NRD defines and the SR_RF_BYPASS_EN switch comment.
REQ-032 Busy bits, pend_cnt and err logic SHALL live in sub-module sr_rf_scoreboard; storage and read muxing stay in sr_regfile_sb.

Verification
REQ-033 Reset, then we=1 wa=5 wd=32'hDEADBEEF; next cycle ra[1]=5 -> rdata port1=32'hDEADBEEF; ra=0 -> 0 always.
REQ-034 iss_valid addr=7; next cycle rbusy for ra=7 =1, pend_cnt=1; cw_valid addr=7 data=32'h12345678 -> next cycle rbusy=0, pend_cnt=0, data=32'h12345678, err=0.
REQ-035 Issue addr 3 twice in successive cycles -> err=1 after second, pend_cnt=1; err persists until rst_n=0.
REQ-036 Same cycle we addr 9 wd=32'h1 and cw_valid addr 9 data=32'h2 (busy) -> reg9=32'h1, busy cleared, err=1.
REQ-037 With SR_RF_BYPASS_EN: reg4 pending, cw_valid addr4 data=32'hCAFE0000 while ra[2]=4 -> same cycle rdata=32'hCAFE0000, rbusy=0; without macro -> old value, rbusy=1.
REQ-038 Issue 4 registers, assert rst_n=0 one cycle -> pend_cnt=0, all reads 0; subsequent completion to one of them -> err=1.
